// File: rtl/timer_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_slave_if
//  Description : Memory-map slave port bundle for the down-counting timer:
//                write data, byte address, write/slave selects, combinational
//                read data and the level interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
interface timer_slave_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] wd;
    logic [31:0]           address;
    logic                  we;
    logic                  re;
    logic [DATA_WIDTH-1:0] rd;
    logic                  irq;

    modport master (
        output wd, address, we, re,
        input  rd, irq
    );

    modport slave (
        input  wd, address, we, re,
        output rd, irq
    );
endinterface
`default_nettype wire

// File: rtl/timer_slave.sv
`default_nettype none
// ============================================================================
//  Module      : timer_slave
//  Description : Memory-mapped down-counting timer with programmable
//                prescaler, one-shot / auto-reload modes, sticky expiry flag
//                and level interrupt. Reads are combinational (same cycle),
//                writes land on the next rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_slave #(
    parameter int DATA_WIDTH     = 32,
    parameter int PRESCALE_WIDTH = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    timer_slave_if.slave   bus
);

    // Word selects decoded from address[4:2]
    localparam logic [2:0] c_sel_ctrl     = 3'd0;
    localparam logic [2:0] c_sel_load     = 3'd1;
    localparam logic [2:0] c_sel_count    = 3'd2;
    localparam logic [2:0] c_sel_status   = 3'd3;
    localparam logic [2:0] c_sel_prescale = 3'd4;

    logic                      r_enable;
    logic                      r_auto_reload;
    logic                      r_irq_en;
    logic [DATA_WIDTH-1:0]     r_load;
    logic [DATA_WIDTH-1:0]     r_count;
    logic                      r_expired;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [PRESCALE_WIDTH-1:0] r_pcnt;

    logic [2:0]                w_sel;
    logic                      w_wr_ctrl;
    logic                      w_wr_load;
    logic                      w_wr_count;
    logic                      w_wr_status;
    logic                      w_wr_prescale;
    logic                      w_tick;
    logic                      w_expire;
    logic [DATA_WIDTH-1:0]     w_rd;
    logic                      w_unused_addr;

    // Only the word index is decoded; the remaining address bits are ignored.
    assign w_sel         = bus.address[4:2];
    assign w_unused_addr = ^{bus.address[31:5], bus.address[1:0]};

    // The master gates both strobes, so a write needs only we.
    assign w_wr_ctrl     = bus.we && (w_sel == c_sel_ctrl);
    assign w_wr_load     = bus.we && (w_sel == c_sel_load);
    assign w_wr_count    = bus.we && (w_sel == c_sel_count);
    assign w_wr_status   = bus.we && (w_sel == c_sel_status);
    assign w_wr_prescale = bus.we && (w_sel == c_sel_prescale);

    // A tick needs an exact match, so lowering PRESCALE below pcnt lets pcnt
    // run through its natural wrap before the next tick.
    assign w_tick   = r_enable && (r_pcnt == r_prescale);
    assign w_expire = w_tick && (r_count == '0);

    // Prescaler: held at zero while disabled, wraps to zero on every tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (!r_enable || w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    // Control bits: a CPU write overrides the one-shot self-disable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable      <= 1'b0;
            r_auto_reload <= 1'b0;
            r_irq_en      <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_enable      <= bus.wd[0];
            r_auto_reload <= bus.wd[1];
            r_irq_en      <= bus.wd[2];
        end else if (w_expire && !r_auto_reload) begin
            r_enable      <= 1'b0;
        end
    end

    // Reload value and prescaler divisor are plain CPU registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_load     <= '0;
            r_prescale <= '0;
        end else begin
            if (w_wr_load) begin
                r_load <= bus.wd;
            end
            if (w_wr_prescale) begin
                r_prescale <= bus.wd[PRESCALE_WIDTH-1:0];
            end
        end
    end

    // Counter: CPU write beats the tick; expiry reloads or parks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= bus.wd;
        end else if (w_tick) begin
            if (r_count != '0) begin
                r_count <= r_count - 1'b1;
            end else if (r_auto_reload) begin
                r_count <= r_load;
            end
        end
    end

    // Sticky expiry flag: a fresh expiry beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_expired <= 1'b0;
        end else if (w_expire) begin
            r_expired <= 1'b1;
        end else if (w_wr_status && bus.wd[0]) begin
            r_expired <= 1'b0;
        end
    end

    // Combinational read mux, forced to zero when the slave is not selected.
    always_comb begin
        w_rd = '0;
        if (bus.re) begin
            case (w_sel)
                c_sel_ctrl:     w_rd = {{(DATA_WIDTH-3){1'b0}}, r_irq_en, r_auto_reload, r_enable};
                c_sel_load:     w_rd = r_load;
                c_sel_count:    w_rd = r_count;
                c_sel_status:   w_rd = {{(DATA_WIDTH-1){1'b0}}, r_expired};
                c_sel_prescale: w_rd = DATA_WIDTH'(r_prescale);
                default:        w_rd = '0;
            endcase
        end
    end

    assign bus.rd  = w_rd;
    assign bus.irq = r_expired & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_timer_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_slave
//  Description : Directed self-checking bench for timer_slave. The driver
//                queues expected read data / irq for every sampled read and a
//                monitor pops and compares at the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_slave;

    localparam logic [31:0] c_ctrl     = 32'h00;
    localparam logic [31:0] c_load     = 32'h04;
    localparam logic [31:0] c_count    = 32'h08;
    localparam logic [31:0] c_status   = 32'h0C;
    localparam logic [31:0] c_prescale = 32'h10;

    typedef struct {
        logic [63:0] name;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    logic clk;
    logic rst;
    logic chk;
    int   n_chk;
    int   n_pass;
    exp_t q[$];

    timer_slave_if #(.DATA_WIDTH(32)) bus ();

    timer_slave #(
        .DATA_WIDTH     (32),
        .PRESCALE_WIDTH (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle write strobe (re low: the slave must still honour we).
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.we = 1'b1; bus.re = 1'b0; bus.address = a; bus.wd = d; chk = 1'b0;
    endtask

    // One-cycle sampled read; expectation is queued for the monitor.
    task automatic rdc(input logic [31:0] a, input logic [31:0] e_rd,
                       input logic e_irq, input logic [63:0] nm, input logic sel);
        exp_t e;
        @(posedge clk); #1;
        bus.we = 1'b0; bus.re = sel; bus.address = a; chk = 1'b1;
        e.name = nm; e.rd = e_rd; e.irq = e_irq;
        q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.we = 1'b0; bus.re = 1'b0; chk = 1'b0;
    endtask

    // Monitor: compare rd and irq mid-cycle against the queued expectation.
    always @(negedge clk) begin
        if (chk) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL no_expect: read sampled with empty scoreboard");
            end else begin
                exp_t e;
                e = q.pop_front();
                n_chk++;
                if (bus.rd !== e.rd)
                    $display("FAIL %s rd: got %h, want %h", e.name, bus.rd, e.rd);
                else
                    n_pass++;
                n_chk++;
                if (bus.irq !== e.irq)
                    $display("FAIL %s irq: got %b, want %b", e.name, bus.irq, e.irq);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        n_chk = 0; n_pass = 0; chk = 1'b0;
        bus.we = 1'b0; bus.re = 1'b0; bus.address = '0; bus.wd = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state: every offset reads zero
        for (int i = 0; i < 8; i++) rdc(32'(i * 4), 32'h0, 1'b0, "rst_val ", 1'b1);

        // One-shot: CTRL=1 lands at edge E
        wr(c_prescale, 32'd0);
        wr(c_count, 32'd3);
        wr(c_ctrl, 32'h1);
        rdc(c_count, 32'd3, 1'b0, "os_c3   ", 1'b1);
        rdc(c_count, 32'd2, 1'b0, "os_c2   ", 1'b1);
        rdc(c_count, 32'd1, 1'b0, "os_c1   ", 1'b1);
        rdc(c_count, 32'd0, 1'b0, "os_c0   ", 1'b1);
        rdc(c_status, 32'd1, 1'b0, "os_stat ", 1'b1);
        rdc(c_ctrl, 32'd0, 1'b0, "os_ctrl ", 1'b1);
        rdc(c_count, 32'd0, 1'b0, "os_hold ", 1'b1);
        wr(c_status, 32'h1);
        rdc(c_status, 32'd0, 1'b0, "os_clr  ", 1'b1);

        // Auto-reload, PRESCALE=1, LOAD=2: expiry every 6 cycles (E+6, E+12)
        wr(c_prescale, 32'd1);
        wr(c_load, 32'd2);
        wr(c_count, 32'd2);
        wr(c_ctrl, 32'h7);
        rdc(c_count, 32'd2, 1'b0, "ar_e0   ", 1'b1);
        rdc(c_count, 32'd2, 1'b0, "ar_e1   ", 1'b1);
        rdc(c_count, 32'd1, 1'b0, "ar_e2   ", 1'b1);
        rdc(c_count, 32'd1, 1'b0, "ar_e3   ", 1'b1);
        rdc(c_count, 32'd0, 1'b0, "ar_e4   ", 1'b1);
        rdc(c_count, 32'd0, 1'b0, "ar_e5   ", 1'b1);
        rdc(c_status, 32'd1, 1'b1, "ar_exp  ", 1'b1);
        wr(c_status, 32'h1);                         // clear at E+8
        rdc(c_status, 32'd0, 1'b0, "ar_clr  ", 1'b1);
        rdc(c_count, 32'd1, 1'b0, "ar_e9   ", 1'b1);
        rdc(c_count, 32'd0, 1'b0, "ar_e10  ", 1'b1);
        wr(c_status, 32'h1);                         // clear collides with expiry at E+12
        rdc(c_status, 32'd1, 1'b1, "set_win ", 1'b1);
        wr(c_count, 32'h55);                         // write collides with tick at E+14
        rdc(c_count, 32'h55, 1'b1, "cw_win  ", 1'b1);
        rdc(c_count, 32'h55, 1'b1, "cw_hold ", 1'b1);
        rdc(c_count, 32'h54, 1'b1, "cw_dec  ", 1'b1);
        wr(c_ctrl, 32'h0);                           // lands on tick at E+18: 0x54 -> 0x53
        wr(c_status, 32'h1);

        // Unmapped write and select gating
        wr(32'h14, 32'hDEADBEEF);
        rdc(c_ctrl, 32'd0, 1'b0, "um_ctrl ", 1'b1);
        rdc(c_load, 32'd2, 1'b0, "um_load ", 1'b1);
        rdc(c_count, 32'h53, 1'b0, "um_count", 1'b1);
        rdc(c_status, 32'd0, 1'b0, "um_stat ", 1'b1);
        rdc(c_prescale, 32'd1, 1'b0, "um_presc", 1'b1);
        rdc(32'h14, 32'd0, 1'b0, "um_14   ", 1'b1);
        rdc(c_load, 32'd0, 1'b0, "re_gate ", 1'b0);
        rdc(32'h1C, 32'd0, 1'b0, "um_1c   ", 1'b1);

        // Reset mid-count
        wr(c_prescale, 32'd0);
        wr(c_count, 32'd5);
        wr(c_load, 32'd9);
        wr(c_ctrl, 32'h5);
        rdc(c_count, 32'd5, 1'b0, "mr_c5   ", 1'b1);
        rdc(c_count, 32'd4, 1'b0, "mr_c4   ", 1'b1);
        @(posedge clk); #1;
        bus.we = 1'b0; bus.re = 1'b0; chk = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) rdc(32'(i * 4), 32'h0, 1'b0, "mr_zero ", 1'b1);

        idle();
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL leftover: got %0d unchecked entries, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
